lsu_mem_ctrl: RTL and testbench

//  Sequences data-memory accesses for the MEM stage: accepts one load/store per

---
 rtl/lsu_mem_ctrl_if.sv | 20 ++
 rtl/lsu_mem_ctrl.sv | 119 +++++++++++
 tb/tb_lsu_mem_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: data-memory port between the load/store unit and the data memory
interface lsu_mem_ctrl_if;
    logic        dm_req;
    logic [3:0]  dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: MEM-stage load/store sequencer with alignment checks, byte enables and load extension
module lsu_mem_ctrl #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_valid,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            funct3,
    input  logic [31:0]           alu_result,
    input  logic [31:0]           rs2_data,
    lsu_mem_ctrl_if.master        dm,
    output logic                  lsu_stall,
    output logic                  load_valid,
    output logic [31:0]           load_data_final,
    output logic                  lsu_exc,
    output logic [1:0]            lsu_cause
);
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    state_t      state, state_nxt;
    logic [CW-1:0] cnt;
    logic        is_load;
    logic [2:0]  f_q;
    logic [1:0]  off_q;
    logic [3:0]  we_q;
    logic        op, ill, mis, err, accept, tmo;
    logic [3:0]  we_n;
    logic [31:0] wd_n, sh, ext;
    logic [15:0] half;

    // request decode: illegal encodings take priority over misalignment
    always_comb begin
        op     = mem_valid & (MemRead | MemWrite);
        ill    = (MemRead & MemWrite)
               | (MemRead  & (funct3 == 3'b011 || funct3[2:1] == 2'b11))
               | (MemWrite & (funct3 == 3'b011 || funct3[2]));
        mis    = (funct3[1:0] == 2'b01 && alu_result[0])
               | (funct3[1:0] == 2'b10 && alu_result[1:0] != 2'b00);
        err    = (state == IDLE) & op & (ill | mis);
        accept = (state == IDLE) & op & ~ill & ~mis;
        we_n   = !MemWrite ? 4'b0000 :
                 funct3[1:0] == 2'b00 ? 4'b0001 << alu_result[1:0] :
                 funct3[1:0] == 2'b01 ? 4'b0011 << {alu_result[1], 1'b0} : 4'b1111;
        wd_n   = funct3[1:0] == 2'b00 ? {4{rs2_data[7:0]}} :
                 funct3[1:0] == 2'b01 ? {2{rs2_data[15:0]}} : rs2_data;
    end

    // load lane extraction and sign/zero extension from the registered funct3/offset
    always_comb begin
        sh   = dm.dm_rdata >> {off_q, 3'b000};
        half = off_q[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];
        ext  = f_q[1:0] == 2'b00 ? {{24{~f_q[2] & sh[7]}}, sh[7:0]} :
               f_q[1:0] == 2'b01 ? {{16{~f_q[2] & half[15]}}, half} : dm.dm_rdata;
        tmo  = (state == WAIT_R) & ~dm.dm_rvalid & (cnt == CW'(TIMEOUT_CYC - 1));
    end

    // next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        lsu_stall = 1'b0;
        dm.dm_req = 1'b0;
        dm.dm_we  = 4'b0000;
        case (state)
            IDLE: begin
                lsu_stall = accept;
                if (accept) state_nxt = REQ;
            end
            REQ: begin
                lsu_stall = 1'b1;
                dm.dm_req = 1'b1;
                dm.dm_we  = we_q;
                if (dm.dm_gnt) state_nxt = is_load ? WAIT_R : DONE;
            end
            WAIT_R: begin
                lsu_stall = 1'b1;
                if (dm.dm_rvalid || tmo) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state, captured request, result and exception registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            is_load         <= 1'b0;
            f_q             <= 3'b000;
            off_q           <= 2'b00;
            we_q            <= 4'b0000;
            dm.dm_addr      <= 32'h0;
            dm.dm_wdata     <= 32'h0;
            load_valid      <= 1'b0;
            load_data_final <= 32'h0;
            lsu_exc         <= 1'b0;
            lsu_cause       <= 2'b00;
        end else begin
            state <= state_nxt;
            cnt   <= (state == WAIT_R) ? cnt + 1'b1 : '0;
            if (accept) begin
                is_load     <= MemRead;
                f_q         <= funct3;
                off_q       <= alu_result[1:0];
                we_q        <= we_n;
                dm.dm_addr  <= {alu_result[31:2], 2'b00};
                dm.dm_wdata <= wd_n;
            end
            load_valid <= (state == WAIT_R) & (dm.dm_rvalid | tmo);
            if (state == WAIT_R && dm.dm_rvalid) load_data_final <= ext;
            else if (tmo) load_data_final <= 32'h0;
            lsu_exc   <= err | tmo;
            lsu_cause <= tmo ? 2'b11 : err ? (ill ? 2'b10 : 2'b01) : 2'b00;
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed self-checking bench for the load/store sequencer
module tb_lsu_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] alu_result = 32'h0, rs2_data = 32'h0;
    logic        lsu_stall, load_valid, lsu_exc;
    logic [31:0] load_data_final;
    logic [1:0]  lsu_cause;
    int checks = 0, errors = 0;

    int          r_stall, r_lv, r_exc;
    logic [1:0]  r_cause;
    logic [31:0] r_data, r_addr, r_wdata;
    logic [3:0]  r_we;
    logic        r_req, r_stable;

    lsu_mem_ctrl_if bus();

    lsu_mem_ctrl #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .MemRead(MemRead),
        .MemWrite(MemWrite), .funct3(funct3), .alu_result(alu_result),
        .rs2_data(rs2_data), .dm(bus), .lsu_stall(lsu_stall),
        .load_valid(load_valid), .load_data_final(load_data_final),
        .lsu_exc(lsu_exc), .lsu_cause(lsu_cause)
    );

    always #5 clk = ~clk;

    // drives one access for 24 cycles acting as memory; gd = REQ cycles before gnt, rdly = WAIT_R cycles before rvalid (-1 never)
    task automatic access(input logic rd, input logic wr, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] wd, input int gd, input int rdly, input logic [31:0] rdat);
        int rq = 0, wc = 0;
        logic wt = 1'b0, g;
        r_stall = 0; r_lv = 0; r_exc = 0; r_cause = 2'b00; r_data = 32'hx;
        r_req = 1'b0; r_stable = 1'b1; r_addr = 32'hx; r_wdata = 32'hx; r_we = 4'hx;
        mem_valid = 1'b1; MemRead = rd; MemWrite = wr; funct3 = f; alu_result = a; rs2_data = wd;
        bus.dm_rdata = rdat;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            r_stall += int'(lsu_stall);
            r_lv    += int'(load_valid);
            if (lsu_exc) begin r_exc++; r_cause = lsu_cause; end
            if (load_valid) r_data = load_data_final;
            if (bus.dm_req) begin
                if (!r_req) begin r_addr = bus.dm_addr; r_we = bus.dm_we; r_wdata = bus.dm_wdata; end
                else if (r_addr !== bus.dm_addr || r_we !== bus.dm_we || r_wdata !== bus.dm_wdata) r_stable = 1'b0;
                r_req = 1'b1;
            end
            g = bus.dm_req && rq >= gd;
            if (bus.dm_req) rq++;
            bus.dm_gnt = g;
            bus.dm_rvalid = wt && wc == rdly;
            if (wt) wc++;
            @(posedge clk); #1;
            mem_valid = 1'b0;
            if (g && rd) wt = 1'b1;
        end
        bus.dm_gnt = 1'b0; bus.dm_rvalid = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (bus.dm_req !== 1'b0 || bus.dm_we !== 4'h0) begin errors++; $display("FAIL reset_req req=%b we=%b exp 0/0000", bus.dm_req, bus.dm_we); end
        checks++; if (bus.dm_addr !== 32'h0 || bus.dm_wdata !== 32'h0) begin errors++; $display("FAIL reset_bus addr=%h wdata=%h exp 0", bus.dm_addr, bus.dm_wdata); end
        checks++; if ({load_valid, lsu_exc, lsu_cause, lsu_stall} !== 5'b0 || load_data_final !== 32'h0) begin errors++; $display("FAIL reset_out lv=%b exc=%b cause=%b stall=%b data=%h exp 0", load_valid, lsu_exc, lsu_cause, lsu_stall, load_data_final); end
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_byte;
        access(1, 0, 3'b000, 32'h0000_1003, 0, 0, 0, 32'h80FF_1234);
        checks++; if (r_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h exp ffffff80", r_data); end
        checks++; if (r_stall != 3) begin errors++; $display("FAIL lb_stall got %0d exp 3", r_stall); end
        checks++; if (r_lv != 1) begin errors++; $display("FAIL lb_valid_pulse got %0d exp 1", r_lv); end
        checks++; if (r_addr !== 32'h0000_1000 || r_we !== 4'b0000) begin errors++; $display("FAIL lb_bus addr=%h we=%b exp 00001000/0000", r_addr, r_we); end
        access(1, 0, 3'b100, 32'h0000_1001, 0, 0, 0, 32'h80FF_1234);
        checks++; if (r_data !== 32'h0000_0012) begin errors++; $display("FAIL lbu_data got %h exp 00000012", r_data); end
        access(1, 0, 3'b000, 32'h0000_1002, 0, 0, 0, 32'h80FF_1234);
        checks++; if (r_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL lb_b2_data got %h exp ffffffff", r_data); end
    endtask

    task automatic test_load_half_word;
        access(1, 0, 3'b101, 32'h0000_1002, 0, 0, 0, 32'hBEEF_0000);
        checks++; if (r_data !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_data got %h exp 0000beef", r_data); end
        access(1, 0, 3'b001, 32'h0000_1002, 0, 0, 0, 32'hBEEF_0000);
        checks++; if (r_data !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh_data got %h exp ffffbeef", r_data); end
        access(1, 0, 3'b001, 32'h0000_1000, 0, 0, 0, 32'hBEEF_7A55);
        checks++; if (r_data !== 32'h0000_7A55) begin errors++; $display("FAIL lh_lo_data got %h exp 00007a55", r_data); end
        access(1, 0, 3'b010, 32'h0000_1008, 0, 1, 2, 32'h80FF_1234);
        checks++; if (r_data !== 32'h80FF_1234) begin errors++; $display("FAIL lw_data got %h exp 80ff1234", r_data); end
        checks++; if (r_stall != 6) begin errors++; $display("FAIL lw_slow_stall got %0d exp 6", r_stall); end
    endtask

    task automatic test_store;
        access(0, 1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 3, -1, 32'h0);
        checks++; if (r_we !== 4'b1100) begin errors++; $display("FAIL sh_we got %b exp 1100", r_we); end
        checks++; if (r_wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata got %h exp abcdabcd", r_wdata); end
        checks++; if (r_addr !== 32'h0000_2000) begin errors++; $display("FAIL sh_addr got %h exp 00002000", r_addr); end
        checks++; if (r_stable !== 1'b1) begin errors++; $display("FAIL sh_stable got %b exp 1", r_stable); end
        checks++; if (r_stall != 5 || r_lv != 0) begin errors++; $display("FAIL sh_stall stall=%0d lv=%0d exp 5/0", r_stall, r_lv); end
        access(0, 1, 3'b000, 32'h0000_2003, 32'h0000_00A5, 0, -1, 32'h0);
        checks++; if (r_we !== 4'b1000 || r_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb we=%b wdata=%h exp 1000/a5a5a5a5", r_we, r_wdata); end
        checks++; if (r_stall != 2) begin errors++; $display("FAIL sb_stall got %0d exp 2", r_stall); end
        access(0, 1, 3'b010, 32'h0000_2004, 32'hDEAD_BEEF, 0, -1, 32'h0);
        checks++; if (r_we !== 4'b1111 || r_wdata !== 32'hDEAD_BEEF || r_addr !== 32'h0000_2004) begin errors++; $display("FAIL sw we=%b wdata=%h addr=%h exp 1111/deadbeef/00002004", r_we, r_wdata, r_addr); end
    endtask

    task automatic test_errors;
        access(1, 0, 3'b010, 32'h0000_1006, 0, 0, 0, 32'h0);
        checks++; if (r_exc != 1 || r_cause !== 2'b01) begin errors++; $display("FAIL lw_misaligned exc=%0d cause=%b exp 1/01", r_exc, r_cause); end
        checks++; if (r_req !== 1'b0 || r_stall != 0) begin errors++; $display("FAIL lw_misaligned_noreq req=%b stall=%0d exp 0/0", r_req, r_stall); end
        access(1, 0, 3'b011, 32'h0000_1000, 0, 0, 0, 32'h0);
        checks++; if (r_exc != 1 || r_cause !== 2'b10 || r_req !== 1'b0) begin errors++; $display("FAIL ld_f011 exc=%0d cause=%b req=%b exp 1/10/0", r_exc, r_cause, r_req); end
        access(1, 1, 3'b000, 32'h0000_1000, 0, 0, 0, 32'h0);
        checks++; if (r_exc != 1 || r_cause !== 2'b10) begin errors++; $display("FAIL rd_and_wr exc=%0d cause=%b exp 1/10", r_exc, r_cause); end
        access(0, 1, 3'b100, 32'h0000_1000, 0, 0, 0, 32'h0);
        checks++; if (r_exc != 1 || r_cause !== 2'b10) begin errors++; $display("FAIL st_f100 exc=%0d cause=%b exp 1/10", r_exc, r_cause); end
        access(0, 1, 3'b001, 32'h0000_1001, 0, 0, 0, 32'h0);
        checks++; if (r_exc != 1 || r_cause !== 2'b01 || r_req !== 1'b0) begin errors++; $display("FAIL sh_misaligned exc=%0d cause=%b req=%b exp 1/01/0", r_exc, r_cause, r_req); end
    endtask

    task automatic test_timeout;
        access(1, 0, 3'b010, 32'h0000_3000, 0, 0, -1, 32'h0);
        checks++; if (r_exc != 1 || r_cause !== 2'b11) begin errors++; $display("FAIL timeout exc=%0d cause=%b exp 1/11", r_exc, r_cause); end
        checks++; if (r_stall != 18) begin errors++; $display("FAIL timeout_stall got %0d exp 18", r_stall); end
        checks++; if (load_data_final !== 32'h0 || lsu_stall !== 1'b0) begin errors++; $display("FAIL timeout_after data=%h stall=%b exp 0/0", load_data_final, lsu_stall); end
    endtask

    task automatic test_back_to_back;
        mem_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; funct3 = 3'b010;
        alu_result = 32'h0000_5000; rs2_data = 32'h0BAD_F00D; bus.dm_gnt = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        MemRead = 1'b1; MemWrite = 1'b0; alu_result = 32'h0000_6000; bus.dm_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        checks++; if (lsu_stall !== 1'b0 || bus.dm_req !== 1'b0) begin errors++; $display("FAIL b2b_done stall=%b req=%b exp 0/0", lsu_stall, bus.dm_req); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (lsu_stall !== 1'b1) begin errors++; $display("FAIL b2b_accept stall=%b exp 1", lsu_stall); end
        @(posedge clk); #1;
        mem_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.dm_req !== 1'b1 || bus.dm_addr !== 32'h0000_6000 || bus.dm_we !== 4'b0000) begin errors++; $display("FAIL b2b_req req=%b addr=%h we=%b exp 1/00006000/0000", bus.dm_req, bus.dm_addr, bus.dm_we); end
        @(posedge clk); #1;
        bus.dm_gnt = 1'b0; bus.dm_rvalid = 1'b1;
        @(posedge clk); #1;
        bus.dm_rvalid = 1'b0;
        @(negedge clk);
        checks++; if (load_valid !== 1'b1 || load_data_final !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_load lv=%b data=%h exp 1/cafef00d", load_valid, load_data_final); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        mem_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010;
        alu_result = 32'h0000_4000; bus.dm_gnt = 1'b1;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        @(posedge clk); #1;
        bus.dm_gnt = 1'b0;
        @(negedge clk);
        checks++; if (lsu_stall !== 1'b1 || bus.dm_req !== 1'b0) begin errors++; $display("FAIL mid_wait stall=%b req=%b exp 1/0", lsu_stall, bus.dm_req); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.dm_req !== 1'b0 || lsu_stall !== 1'b0 || bus.dm_addr !== 32'h0 || load_data_final !== 32'h0) begin errors++; $display("FAIL mid_reset req=%b stall=%b addr=%h data=%h exp 0", bus.dm_req, lsu_stall, bus.dm_addr, load_data_final); end
        @(posedge clk); #1;
        rst_n = 1'b1; bus.dm_rvalid = 1'b1; bus.dm_rdata = 32'h1111_1111;
        @(posedge clk); #1;
        bus.dm_rvalid = 1'b0;
        @(negedge clk);
        checks++; if (load_valid !== 1'b0 || load_data_final !== 32'h0 || lsu_stall !== 1'b0) begin errors++; $display("FAIL late_rvalid lv=%b data=%h stall=%b exp 0/0/0", load_valid, load_data_final, lsu_stall); end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.dm_gnt = 1'b0; bus.dm_rvalid = 1'b0; bus.dm_rdata = 32'h0;
        test_reset;
        test_load_byte;
        test_load_half_word;
        test_store;
        test_errors;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
